// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter:
// FSM state encoding, access owner tags and the word width.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU priority, DMA starvation guard,
// bounded DMA burst lock, registered read return.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_BURST    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [WORD_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [WORD_W-1:0] dma_addr,
  input  logic [WORD_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [WORD_W-1:0] dma_rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_write_data,
  input  logic [WORD_W-1:0] mem_read_data,
  output logic              misalign_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic CAN_LOCK = (MAX_BURST > 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [BW-1:0]     burst_q, burst_d;
  owner_e            own;
  owner_e            rown_q, rown_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] crd_q, crd_d;
  logic [WORD_W-1:0] drd_q, drd_d;
  logic [WORD_W-1:0] rd_v;

  logic              dma_pri, dma_win, gnt;
  logic              sel_we, aligned;
  logic [WORD_W-1:0] sel_addr, sel_wdata;

  always_comb begin
    dma_pri = dma_req &
      ((state_q == ST_LOCK) | (starve_q == STARVE_MAX));
    own = OWN_NONE;
    if (dma_pri)      own = OWN_DMA;
    else if (cpu_req) own = OWN_CPU;
    else if (dma_req) own = OWN_DMA;

    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    unique case (own)
      OWN_CPU: begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
      end
      OWN_DMA: begin
        sel_we    = dma_we;
        sel_addr  = dma_addr;
        sel_wdata = dma_wdata;
      end
      default: ;
    endcase

    gnt     = (own != OWN_NONE);
    dma_win = (own == OWN_DMA);
    aligned = (sel_addr[1:0] == 2'b00);
  end

  // Outputs are forced low while reset is asserted; state logic is not.
  assign cpu_gnt        = rst_n & (own == OWN_CPU);
  assign dma_gnt        = rst_n & dma_win;
  assign mem_write      = rst_n & gnt & sel_we & aligned;
  assign mem_read       = rst_n & gnt & ~sel_we & aligned;
  assign mem_addr       = rst_n ? sel_addr : '0;
  assign mem_write_data = rst_n ? sel_wdata : '0;

  assign cpu_rvalid   = (rown_q == OWN_CPU);
  assign dma_rvalid   = (rown_q == OWN_DMA);
  assign cpu_rdata    = crd_q;
  assign dma_rdata    = drd_q;
  assign misalign_err = err_q;

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dma_win & dma_lock & CAN_LOCK) begin
          state_d = ST_LOCK;
          burst_d = BW'(1);
        end
      end
      ST_LOCK: begin
        if (dma_win & dma_lock & (burst_q < BURST_LAST)) begin
          burst_d = burst_q + 1'b1;
        end else begin
          state_d = ST_IDLE;
          burst_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        burst_d = '0;
      end
    endcase

    starve_d = starve_q;
    if (~dma_req | dma_win)
      starve_d = '0;
    else if (starve_q != STARVE_MAX)
      starve_d = starve_q + 1'b1;

    // Loads and any misaligned access answer one cycle later.
    rown_d = OWN_NONE;
    err_d  = 1'b0;
    crd_d  = crd_q;
    drd_d  = drd_q;
    rd_v   = aligned ? mem_read_data : '0;
    if (gnt & (~aligned | ~sel_we)) begin
      rown_d = own;
      err_d  = ~aligned;
      if (own == OWN_CPU) crd_d = rd_v;
      else                drd_d = rd_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      burst_q  <= '0;
      rown_q   <= OWN_NONE;
      err_q    <= 1'b0;
      crd_q    <= '0;
      drd_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
      rown_q   <= rown_d;
      err_q    <= err_d;
      crd_q    <= crd_d;
      drd_q    <= drd_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed corner sequences
// and random traffic against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  localparam int SL = 8;
  localparam int MB = 4;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_write, mem_read, misalign_err;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;

  dmem_arbiter #(.STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0101;
  endfunction

  // Memory behind the arbiter: combinational read, clocked write.
  logic [31:0] mem [64];
  logic        mem_load;
  assign mem_read_data = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_write_data;
    end
  end

  int n_pass, n_total;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Reference model state
  logic [31:0] model_mem [64];
  int          m_wait, m_run;
  bit          m_lock;
  bit          e_cv, e_dv, e_err;
  logic [31:0] e_crd, e_drd;

  task automatic drv(bit cr, bit cw, logic [31:0] ca, logic [31:0] cd,
                     bit dr, bit dw, bit dl, logic [31:0] da,
                     logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_lock = dl;
    dma_addr = da; dma_wdata = dd;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Checks one cycle against the model, then advances to the next negedge.
  task automatic tick(string tg);
    bit fd, gc, gd, g, we, mis;
    logic [31:0] a, wd, rd;
    #1;
    fd = dma_req && (m_lock || m_wait == SL);
    gd = fd || (dma_req && !cpu_req);
    gc = cpu_req && !fd;
    g  = gc || gd;
    a  = gd ? dma_addr  : (gc ? cpu_addr  : 32'h0);
    wd = gd ? dma_wdata : (gc ? cpu_wdata : 32'h0);
    we = gd ? dma_we : (gc && cpu_we);
    mis = g && (a[1:0] != 2'b00);
    chk({tg, " cpu_gnt"}, 32'(cpu_gnt), 32'(gc));
    chk({tg, " dma_gnt"}, 32'(dma_gnt), 32'(gd));
    chk({tg, " mem_write"}, 32'(mem_write), 32'(g && we && !mis));
    chk({tg, " mem_read"}, 32'(mem_read), 32'(g && !we && !mis));
    chk({tg, " mem_addr"}, mem_addr, a);
    chk({tg, " mem_wdata"}, mem_write_data, wd);
    chk({tg, " cpu_rvalid"}, 32'(cpu_rvalid), 32'(e_cv));
    chk({tg, " dma_rvalid"}, 32'(dma_rvalid), 32'(e_dv));
    chk({tg, " misalign"}, 32'(misalign_err), 32'(e_err));
    chk({tg, " cpu_rdata"}, cpu_rdata, e_crd);
    chk({tg, " dma_rdata"}, dma_rdata, e_drd);
    @(posedge clk);
    e_cv = 0; e_dv = 0; e_err = 0;
    if (g && (mis || !we)) begin
      rd = mis ? 32'h0 : model_mem[a[7:2]];
      e_err = mis;
      if (gc) begin e_cv = 1; e_crd = rd; end
      else    begin e_dv = 1; e_drd = rd; end
    end else if (g) begin
      model_mem[a[7:2]] = wd;
    end
    // A lock run lasts while DMA keeps asking, up to MB beats.
    if (gd && dma_lock && (m_run + 1 < MB)) begin
      m_lock = 1; m_run = m_run + 1;
    end else begin
      m_lock = 0; m_run = 0;
    end
    if (dma_req && !gd) m_wait = (m_wait < SL) ? m_wait + 1 : SL;
    else                m_wait = 0;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_wait = 0; m_run = 0; m_lock = 0;
    e_cv = 0; e_dv = 0; e_err = 0;
    e_crd = 0; e_drd = 0;
  endtask

  task automatic chk_all_zero(string tg);
    chk({tg, " cpu_gnt"}, 32'(cpu_gnt), 0);
    chk({tg, " dma_gnt"}, 32'(dma_gnt), 0);
    chk({tg, " cpu_rvalid"}, 32'(cpu_rvalid), 0);
    chk({tg, " dma_rvalid"}, 32'(dma_rvalid), 0);
    chk({tg, " misalign"}, 32'(misalign_err), 0);
    chk({tg, " mem_wr_rd"}, {30'b0, mem_write, mem_read}, 0);
    chk({tg, " mem_addr"}, mem_addr, 0);
    chk({tg, " cpu_rdata"}, cpu_rdata, 0);
    chk({tg, " dma_rdata"}, dma_rdata, 0);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  typedef struct {
    bit          cr, cw;
    logic [31:0] ca;
    bit          dr, dw;
    logic [31:0] da;
    bit          eg_c, eg_d, e_mw, e_mr;
  } vec_t;

  vec_t vt [10];
  bit   dg_exp [7];

  initial begin
    vt[0] = '{1, 0, 32'h40, 0, 0, 32'h0,  1, 0, 0, 1};
    vt[1] = '{1, 1, 32'h44, 0, 0, 32'h0,  1, 0, 1, 0};
    vt[2] = '{0, 0, 32'h0,  1, 0, 32'h48, 0, 1, 0, 1};
    vt[3] = '{0, 0, 32'h0,  1, 1, 32'h4C, 0, 1, 1, 0};
    vt[4] = '{1, 0, 32'h40, 1, 1, 32'h4C, 1, 0, 0, 1};
    vt[5] = '{0, 0, 32'h0,  1, 1, 32'h51, 0, 1, 0, 0};
    vt[6] = '{0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0};
    vt[7] = '{1, 0, 32'h42, 0, 0, 32'h0,  1, 0, 0, 0};
    vt[8] = '{1, 1, 32'h60, 1, 0, 32'h48, 1, 0, 1, 0};
    vt[9] = '{0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0};
    dg_exp = '{1, 1, 1, 1, 0, 1, 1};

    n_pass = 0; n_total = 0;
    model_reset();
    for (int i = 0; i < 64; i++) model_mem[i] = init_val(i);
    rst_n = 0; mem_load = 1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1; mem_load = 0;

    // CPU load returns next cycle
    drv(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    #1 chk("t1 gnt", 32'(cpu_gnt), 1);
    tick("t1");
    idle();
    #1 chk("t1 rvalid", 32'(cpu_rvalid), 1);
    chk("t1 rdata", cpu_rdata, 32'hDEAD_BEEF);
    tick("t1b");

    for (int i = 0; i < 10; i++) begin
      drv(vt[i].cr, vt[i].cw, vt[i].ca, 32'hC0DE_0000 | 32'(i),
          vt[i].dr, vt[i].dw, 0, vt[i].da, 32'hD0D0_0000 | 32'(i));
      #1;
      chk($sformatf("vec%0d cg", i), 32'(cpu_gnt), 32'(vt[i].eg_c));
      chk($sformatf("vec%0d dg", i), 32'(dma_gnt), 32'(vt[i].eg_d));
      chk($sformatf("vec%0d mw", i), 32'(mem_write), 32'(vt[i].e_mw));
      chk($sformatf("vec%0d mr", i), 32'(mem_read), 32'(vt[i].e_mr));
      tick("vec");
    end

    // Starvation guard: 8 CPU grants then a forced DMA grant
    for (int i = 0; i < 10; i++) begin
      drv(1, 0, 32'h0, 0, 1, 0, 0, 32'h8, 0);
      #1;
      chk($sformatf("t2 c%0d cg", i), 32'(cpu_gnt), 32'(i != 8));
      chk($sformatf("t2 c%0d dg", i), 32'(dma_gnt), 32'(i == 8));
      tick("t2");
    end
    idle(); tick("t2i");

    // Burst lock capped at MB beats
    begin
      int k;
      k = 0;
      for (int i = 0; i < 7; i++) begin
        drv(i >= 1 && i <= 4, 0, 32'h4, 0,
            1, 1, 1, 32'h80 + 32'(k) * 4, 32'hA000 + 32'(k));
        #1;
        chk($sformatf("t3 c%0d dg", i), 32'(dma_gnt), 32'(dg_exp[i]));
        chk($sformatf("t3 c%0d cg", i), 32'(cpu_gnt), 32'(!dg_exp[i]));
        if (dg_exp[i]) k++;
        tick("t3");
      end
    end
    idle(); tick("t3i");
    drv(0, 0, 0, 0, 1, 0, 0, 32'h94, 0);
    tick("t3r");
    idle();
    #1 chk("t3 last wr", dma_rdata, 32'hA005);
    tick("t3j");

    // Misaligned store
    drv(1, 1, 32'h13, 32'h1234, 0, 0, 0, 0, 0);
    #1 chk("t4 gnt", 32'(cpu_gnt), 1);
    chk("t4 no wr", 32'(mem_write), 0);
    tick("t4");
    idle();
    #1 chk("t4 err", 32'(misalign_err), 1);
    chk("t4 rvalid", 32'(cpu_rvalid), 1);
    chk("t4 rdata", cpu_rdata, 0);
    tick("t4b");

    // Store then DMA read of the same word
    drv(1, 1, 32'h20, 32'h55, 0, 0, 0, 0, 0);
    tick("t6a");
    drv(0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
    tick("t6b");
    idle();
    #1 chk("t6 dvalid", 32'(dma_rvalid), 1);
    chk("t6 drdata", dma_rdata, 32'h55);
    tick("t6c");

    // Async reset inside a lock with a read in flight
    drv(0, 0, 0, 0, 1, 0, 1, 32'h24, 0);
    tick("t5a");
    drv(1, 0, 32'h28, 0, 1, 0, 1, 32'h24, 0);
    #1 rst_n = 0;
    #1 chk_all_zero("t5 rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    drv(1, 0, 32'h28, 0, 0, 0, 0, 0, 0);
    #1 chk("t5 cpu first", 32'(cpu_gnt), 1);
    tick("t5b");
    idle(); tick("t5c");

    for (int i = 0; i < 500; i++) begin
      drv($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
          rnd_addr(), $urandom(),
          $urandom_range(0, 9) < 5, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, rnd_addr(), $urandom());
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
